// File: rtl/uart_tx_arb.sv
// Frame-granular round-robin arbiter sharing one UART transmitter among N_REQ
// byte-stream requesters, with an inter-frame idle gap and a stalled-owner timeout.
module uart_tx_arb #(
  parameter int N_REQ        = 4,
  parameter int N_BITS       = 8,
  parameter int GAP_CLKS     = 217,
  parameter int HOLD_TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*N_BITS-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          ack,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          abort,
  output logic                      tx_start,
  output logic [N_BITS-1:0]         tx_data,
  input  logic                      tx_busy,
  input  logic                      tx_done
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = $clog2(HOLD_TIMEOUT) + 1;
  localparam int GW = $clog2(GAP_CLKS) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_DONE, HOLD, GAP} state_e;
  // With no gap configured a released grant goes straight back to arbitration.
  localparam state_e REL_ST = state_e'((GAP_CLKS == 0) ? IDLE : GAP);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               last_q, last_d;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;

  logic [IW-1:0]      pick, cand;
  logic               pick_vld;
  logic               own_req, own_last, issue, timeout;
  logic [N_BITS-1:0]  own_data;

  assign own_req  = req[owner_q];
  assign own_last = req_last[owner_q];
  assign own_data = req_data[owner_q*N_BITS +: N_BITS];
  assign issue    = (state_q == SEND) && !tx_busy && own_req;
  assign timeout  = (state_q == HOLD) && !own_req && (hold_cnt_q == HOLD_LAST);
  assign grant    = grant_q;

  // First set request strictly after the last owner, wrapping modulo N_REQ.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(rr_ptr_q) + k) % N_REQ);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= IW'(N_REQ - 1);
      last_q     <= 1'b0;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      IDLE: if (pick_vld) begin
        owner_d       = pick;
        grant_d       = '0;
        grant_d[pick] = 1'b1;
        state_d       = SEND;
      end
      SEND: if (!tx_busy) begin
        if (own_req) begin
          last_d  = own_last;
          state_d = WAIT_DONE;
        end else begin
          hold_cnt_d = '0;
          state_d    = HOLD;
        end
      end
      WAIT_DONE: if (tx_done) begin
        if (last_q) begin
          rr_ptr_d  = owner_q;
          grant_d   = '0;
          gap_cnt_d = '0;
          state_d   = REL_ST;
        end else if (own_req) begin
          state_d = SEND;
        end else begin
          hold_cnt_d = '0;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        hold_cnt_d = hold_cnt_q + HW'(1);
        if (own_req) begin
          state_d = SEND;
        end else if (hold_cnt_q == HOLD_LAST) begin
          rr_ptr_d  = owner_q;
          grant_d   = '0;
          gap_cnt_d = '0;
          state_d   = REL_ST;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
        else                       gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack      = '0;
    abort    = '0;
    tx_start = 1'b0;
    tx_data  = '0;
    if (issue) begin
      tx_start     = 1'b1;
      tx_data      = own_data;
      ack[owner_q] = 1'b1;
    end
    if (timeout) abort[owner_q] = 1'b1;
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: cycle table for one frame, then handwritten
// sequences against a small transmitter model for fairness, gap, timeout and reset.
module tb_uart_tx_arb;
  localparam int N = 4, NB = 8, G = 4, T = 16, CHAR = 6;

  logic            clk, rst;
  logic [N-1:0]    req, req_last, ack, grant, abort;
  logic [N*NB-1:0] req_data;
  logic            tx_start, tx_busy, tx_done;
  logic [NB-1:0]   tx_data;

  logic auto_tx, force_busy, tb_busy, tb_done, m_done;
  int   m_cnt;
  int   cyc = 0, last_done_cyc = -1, stray = 0, ab_cnt = 0;
  int   st_own[$], st_dat[$], st_gap[$];
  bit   st_ok[$];
  int   errors = 0, checks = 0;

  uart_tx_arb #(.N_REQ(N), .N_BITS(NB), .GAP_CLKS(G), .HOLD_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .grant(grant), .abort(abort), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign tx_busy = auto_tx ? ((m_cnt != 0) | force_busy) : tb_busy;
  assign tx_done = auto_tx ? m_done : tb_done;

  // Transmitter stand-in: CHAR busy cycles, then a done pulse with busy low.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
    end else begin
      m_done <= (m_cnt == 1);
      if (tx_start && m_cnt == 0) m_cnt <= CHAR;
      else if (m_cnt != 0)        m_cnt <= m_cnt - 1;
    end
  end

  function automatic int oh2i(input logic [N-1:0] g);
    int r = -1;
    for (int i = 0; i < N; i++) if (g[i] && r < 0) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    if (tx_done) last_done_cyc <= cyc;
    if (tx_start) begin
      st_own.push_back(oh2i(grant));
      st_dat.push_back(int'(tx_data));
      st_gap.push_back(cyc - last_done_cyc);
      st_ok.push_back((ack == grant) && $onehot(grant));
    end
    if (tx_start != (ack != '0)) stray <= stray + 1;
    if (abort != '0) ab_cnt <= ab_cnt + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; req_last = '0; req_data = '0;
    tb_busy = 1'b0; tb_done = 1'b0; force_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_ack(input int idx, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (ack[idx]) got = 1'b1;
    end
    chk({nm, "_ack"}, 64'(got), 64'd1);
  endtask

  task automatic wait_starts(input int want, input string nm);
    for (int i = 0; i < 600 && st_own.size() < want; i++) @(negedge clk);
    chk({nm, "_count"}, 64'(st_own.size() >= want), 64'd1);
  endtask

  typedef struct {
    logic [3:0]  req, last;
    logic [31:0] data;
    logic        busy, done;
    logic [3:0]  e_grant, e_ack;
    logic        e_start;
    logic [7:0]  e_data;
    logic [3:0]  e_abort;
  } vec_t;

  function automatic vec_t mk(logic [3:0] rq, logic [3:0] ls, logic [31:0] d, logic b,
                              logic dn, logic [3:0] g, logic [3:0] a, logic s, logic [7:0] td);
    vec_t v;
    v.req = rq; v.last = ls; v.data = d; v.busy = b; v.done = dn;
    v.e_grant = g; v.e_ack = a; v.e_start = s; v.e_data = td; v.e_abort = 4'b0;
    return v;
  endfunction

  vec_t tv[17];

  initial begin : wdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int base, ab0, nbad;
    bit found;
    // Requester 1 sends 41,42,43; then requester 0 (raised during the gap) sends 77.
    tv[0]  = mk(4'b0010, 4'b0000, 32'h4100, 0, 0, 4'b0000, 4'b0000, 0, 8'h00);
    tv[1]  = mk(4'b0010, 4'b0000, 32'h4100, 0, 0, 4'b0010, 4'b0010, 1, 8'h41);
    tv[2]  = mk(4'b0010, 4'b0000, 32'h4200, 1, 0, 4'b0010, 4'b0000, 0, 8'h00);
    tv[3]  = mk(4'b0010, 4'b0000, 32'h4200, 0, 1, 4'b0010, 4'b0000, 0, 8'h00);
    tv[4]  = mk(4'b0010, 4'b0000, 32'h4200, 0, 0, 4'b0010, 4'b0010, 1, 8'h42);
    tv[5]  = mk(4'b0010, 4'b0010, 32'h4300, 1, 0, 4'b0010, 4'b0000, 0, 8'h00);
    tv[6]  = mk(4'b0010, 4'b0010, 32'h4300, 0, 1, 4'b0010, 4'b0000, 0, 8'h00);
    tv[7]  = mk(4'b0010, 4'b0010, 32'h4300, 0, 0, 4'b0010, 4'b0010, 1, 8'h43);
    tv[8]  = mk(4'b0000, 4'b0000, 32'h0000, 1, 0, 4'b0010, 4'b0000, 0, 8'h00);
    tv[9]  = mk(4'b0000, 4'b0000, 32'h0000, 0, 1, 4'b0010, 4'b0000, 0, 8'h00);
    tv[10] = mk(4'b0001, 4'b0001, 32'h0077, 0, 0, 4'b0000, 4'b0000, 0, 8'h00);
    tv[11] = mk(4'b0001, 4'b0001, 32'h0077, 0, 1, 4'b0000, 4'b0000, 0, 8'h00);
    tv[12] = mk(4'b0001, 4'b0001, 32'h0077, 0, 0, 4'b0000, 4'b0000, 0, 8'h00);
    tv[13] = mk(4'b0001, 4'b0001, 32'h0077, 0, 0, 4'b0000, 4'b0000, 0, 8'h00);
    tv[14] = mk(4'b0001, 4'b0001, 32'h0077, 0, 0, 4'b0000, 4'b0000, 0, 8'h00);
    tv[15] = mk(4'b0001, 4'b0001, 32'h0077, 0, 0, 4'b0001, 4'b0001, 1, 8'h77);
    tv[16] = mk(4'b0000, 4'b0000, 32'h0000, 1, 0, 4'b0001, 4'b0000, 0, 8'h00);

    auto_tx = 1'b0;
    rst = 1'b0; req = '0; req_last = '0; req_data = '0;
    tb_busy = 1'b0; tb_done = 1'b0; force_busy = 1'b0;
    #1 chk("reset_outputs", 64'({grant, ack, tx_start, tx_data, abort}), 64'd0);
    do_reset();

    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      req = tv[i].req; req_last = tv[i].last; req_data = tv[i].data;
      tb_busy = tv[i].busy; tb_done = tv[i].done;
      @(negedge clk);
      chk($sformatf("row%0d", i), 64'({grant, ack, tx_start, tx_data, abort}),
          64'({tv[i].e_grant, tv[i].e_ack, tv[i].e_start, tv[i].e_data, tv[i].e_abort}));
    end

    // Fairness: 0,2,3 always requesting single-byte frames.
    auto_tx = 1'b1;
    do_reset();
    base = st_own.size();
    @(posedge clk); #1 req = 4'b1101; req_last = 4'b1101; req_data = 32'hA300_A2A0 & 32'hFFFF_00FF;
    req_data = {8'hA3, 8'hA2, 8'h00, 8'hA0};
    wait_starts(base + 6, "rr");
    @(posedge clk); #1 req = '0;
    if (st_own.size() >= base + 6)
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("rr_own%0d", k), 64'(st_own[base+k]), 64'((k % 3 == 0) ? 0 : (k % 3 == 1) ? 2 : 3));
        chk($sformatf("rr_dat%0d", k), 64'(st_dat[base+k]), 64'((k % 3 == 0) ? 8'hA0 : (k % 3 == 1) ? 8'hA2 : 8'hA3));
        if (k > 0) chk($sformatf("rr_gap%0d", k), 64'(st_gap[base+k]), 64'(G + 2));
      end

    // Requester 1 arrives mid-frame of requester 0 and must wait for frame end plus gap.
    do_reset();
    base = st_own.size();
    @(posedge clk); #1 req = 4'b0001; req_last = 4'b0000; req_data = 32'h0000_0010;
    wait_ack(0, "mf0");
    @(posedge clk); #1 req = 4'b0011; req_last = 4'b0010; req_data = 32'h0000_5511;
    wait_ack(0, "mf1");
    @(posedge clk); #1 req_last = 4'b0011; req_data = 32'h0000_5512;
    wait_ack(0, "mf2");
    @(posedge clk); #1 req = 4'b0010;
    wait_starts(base + 4, "mf");
    @(posedge clk); #1 req = '0;
    if (st_own.size() >= base + 4) begin
      chk("mf_seq", 64'({st_own[base][7:0], st_dat[base][7:0], st_own[base+1][7:0], st_dat[base+1][7:0],
                         st_own[base+2][7:0], st_dat[base+2][7:0], st_own[base+3][7:0], st_dat[base+3][7:0]}),
          64'h00_10_00_11_00_12_01_55);
      chk("mf_cadence", 64'({st_gap[base+1][7:0], st_gap[base+2][7:0]}), 64'h0101);
      chk("mf_gap55", 64'(st_gap[base+3]), 64'(G + 2));
    end

    // Requester 2 stalls mid-frame: timeout abort, next owner searched from 3.
    do_reset();
    base = st_own.size();
    ab0 = ab_cnt;
    @(posedge clk); #1 req = 4'b0100; req_last = 4'b0000; req_data = 32'h0022_0000;
    wait_ack(2, "to");
    @(posedge clk); #1 req = 4'b1011; req_last = 4'b1011; req_data = 32'h3322_3130;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (abort != '0) found = 1'b1;
    end
    chk("to_abort_seen", 64'(found), 64'd1);
    if (found) begin
      chk("to_abort_val", 64'({abort, grant}), 64'h44);
      chk("to_abort_time", 64'(cyc - last_done_cyc), 64'(T));
      @(negedge clk);
      chk("to_grant_clr", 64'(grant), 64'd0);
    end
    wait_starts(base + 2, "to");
    @(posedge clk); #1 req = '0;
    if (st_own.size() >= base + 2) begin
      chk("to_next_own", 64'({st_own[base+1][7:0], st_dat[base+1][7:0]}), 64'h0333);
      chk("to_next_gap", 64'(st_gap[base+1]), 64'(T + G + 2));
    end
    chk("to_abort_once", 64'(ab_cnt - ab0), 64'd1);

    // Owner waits under a busy transmitter; start lands on the first idle cycle.
    do_reset();
    force_busy = 1'b1;
    @(posedge clk); #1 req = 4'b0001; req_last = 4'b0001; req_data = 32'h0000_005A;
    nbad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_start || ack != '0) nbad++;
    end
    chk("busy_no_start", 64'(nbad), 64'd0);
    @(posedge clk); #1 force_busy = 1'b0;
    @(negedge clk);
    chk("busy_release", 64'({tx_start, ack, tx_data}), 64'({1'b1, 4'b0001, 8'h5A}));
    @(posedge clk); #1 req = '0;

    // Reset mid-frame: requester 2 owns (rr_ptr=0 after the 5A frame); reset restarts at 0.
    repeat (20) @(posedge clk);
    #1 req = 4'b0101; req_last = 4'b0000; req_data = 32'h0066_0060;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_own", 64'({grant, tx_start, tx_data}), 64'({4'b0100, 1'b1, 8'h66}));
    @(posedge clk); #1;
    chk("rst_wait_grant", 64'(grant), 64'h4);
    rst = 1'b0;
    #1 chk("rst_async", 64'({grant, ack, tx_start, tx_data, abort}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_idle", 64'(grant), 64'd0);
    @(negedge clk);
    chk("rst_restart0", 64'({grant, ack}), 64'h11);
    @(posedge clk); #1 req = '0;

    nbad = 0;
    foreach (st_ok[k]) if (!st_ok[k]) nbad++;
    chk("ack_coincident", 64'(nbad), 64'd0);
    chk("stray_ack", 64'(stray), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
